alu_arbiter: RTL and testbench

Shares the single-cycle `alu` datapath between two independent requesters (port 0 and port 1, e.g. the execute stage and a multicycle helper). Each request is a valid/ready transfer of opcode plus two operands. The granted operation is sequenced through the ALU from registered operands, and the result plus flags are returned on the requester's own response channel. Arbitration is round-robin, and at most one operation is in flight.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/alu.sv | 53 +++++
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcodes, flag record and arbiter FSM states for the
//                ALU and the two-port ALU arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic overflow;
        logic carry;
        logic sign;
        logic zero;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Two-port request/response bundle between the requesters and
//                the shared ALU arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int XLEN = 32
);
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2:0]      req_op0;
    logic [2:0]      req_op1;
    logic [XLEN-1:0] req_a0;
    logic [XLEN-1:0] req_b0;
    logic [XLEN-1:0] req_a1;
    logic [XLEN-1:0] req_b1;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic [3:0]      rsp_flags;

    // Requester side
    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Single-cycle combinational ALU. ADD/SUB wrap, SLT is an
//                unsigned compare, unsupported opcodes produce zero.
//                For SUB the carry flag reports a borrow (a < b unsigned).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [2:0]      op,
    input  wire logic [XLEN-1:0] a,
    input  wire logic [XLEN-1:0] b,
    output      logic [XLEN-1:0] result,
    output      alu_flags_t      flags
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    // Opcode decode into result plus the arithmetic flags
    always_comb begin
        result         = '0;
        flags.overflow = 1'b0;
        flags.carry    = 1'b0;
        case (op)
            ALU_ADD: begin
                result         = w_sum[XLEN-1:0];
                flags.carry    = w_sum[XLEN];
                flags.overflow = (a[XLEN-1] == b[XLEN-1]) && (w_sum[XLEN-1] != a[XLEN-1]);
            end
            ALU_SUB: begin
                result         = w_diff[XLEN-1:0];
                flags.carry    = w_diff[XLEN];
                flags.overflow = (a[XLEN-1] != b[XLEN-1]) && (w_diff[XLEN-1] != a[XLEN-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
        flags.sign = result[XLEN-1];
        flags.zero = (result == '0);
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin sharing of one ALU between two requesters. One
//                operation in flight: IDLE accepts, EXEC computes from the
//                operand registers, RESP holds the result until taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic   clk,
    input  wire logic   reset,
    alu_arbiter_if.slave bus,
    output      logic   busy
);

    arb_state_t      r_state;
    logic            r_last_grant;
    logic            r_grant;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;
    alu_flags_t      r_flags;
    logic [1:0]      r_rsp_valid;

    logic            w_grant;
    logic [1:0]      w_req_ready;
    logic            w_accept;
    logic            w_rsp_fire;
    logic [XLEN-1:0] w_alu_result;
    alu_flags_t      w_alu_flags;

    // Round-robin pick: a lone requester wins, a tie goes to the port not served last
    always_comb begin
        w_grant = 1'b0;
        if (bus.req_valid == 2'b11) begin
            w_grant = ~r_last_grant;
        end else if (bus.req_valid[1]) begin
            w_grant = 1'b1;
        end
    end

    // Ready only in IDLE with something pending; held low while reset is asserted
    always_comb begin
        w_req_ready = 2'b00;
        if ((r_state == ST_IDLE) && !reset && (|bus.req_valid)) begin
            w_req_ready = w_grant ? 2'b10 : 2'b01;
        end
    end

    assign w_accept   = |(w_req_ready & bus.req_valid);
    assign w_rsp_fire = |(r_rsp_valid & bus.rsp_ready);

    alu #(
        .XLEN   (XLEN)
    ) u_alu (
        .op     (r_op),
        .a      (r_a),
        .b      (r_b),
        .result (w_alu_result),
        .flags  (w_alu_flags)
    );

    // Sequencer: capture on accept, compute in EXEC, hold response until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_flags      <= '0;
            r_rsp_valid  <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_grant <= w_grant;
                        r_op    <= w_grant ? bus.req_op1 : bus.req_op0;
                        r_a     <= w_grant ? bus.req_a1  : bus.req_a0;
                        r_b     <= w_grant ? bus.req_b1  : bus.req_b0;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result    <= w_alu_result;
                    r_flags     <= w_alu_flags;
                    r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_fire) begin
                        r_last_grant <= r_grant;
                        r_rsp_valid  <= 2'b00;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_result;
    assign bus.rsp_flags  = r_flags;
    assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed self-checking bench for the two-port ALU arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic clk;
    logic reset;
    logic busy;
    int   checks;
    int   errors;

    alu_arbiter_if #(.XLEN(32)) bus ();

    alu_arbiter #(
        .XLEN  (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request on port p starting just after a rising edge with the DUT
    // idle; returns the req_ready seen before the accepting edge and leaves the
    // bench at the falling edge of the first RESP cycle.
    task automatic issue(input int p, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [1:0] rdy);
        if (p == 0) begin
            bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; bus.req_valid[0] = 1'b1;
        end else begin
            bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; bus.req_valid[1] = 1'b1;
        end
        @(negedge clk);
        rdy = bus.req_ready;
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Accept the response on port p; ends just after the handshake edge
    task automatic release_rsp(input int p);
        bus.rsp_ready[p] = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready[p] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 2'b11;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bus.rsp_result !== 32'h0 || bus.rsp_flags !== 4'h0) begin errors++;
            $display("FAIL reset_rsp_data got=%h/%b exp=0/0000", bus.rsp_result, bus.rsp_flags); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_tie got=%b exp=01", bus.req_ready); end
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_single_add();
        bus.req_op1 = 3'b000; bus.req_a1 = 32'd5; bus.req_b1 = 32'd7; bus.req_valid[1] = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL add_req_ready got=%b exp=10", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 2'b00 || busy !== 1'b1) begin errors++;
            $display("FAIL add_exec got rsp_valid=%b busy=%b exp=00/1", bus.rsp_valid, busy); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("FAIL add_rsp_valid got=%b exp=10", bus.rsp_valid); end
        checks++; if (bus.rsp_result !== 32'd12) begin errors++; $display("FAIL add_result got=%h exp=0000000c", bus.rsp_result); end
        checks++; if (bus.rsp_flags !== 4'b0000) begin errors++; $display("FAIL add_flags got=%b exp=0000", bus.rsp_flags); end
        release_rsp(1);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin errors++;
            $display("FAIL add_back_idle got busy=%b rsp_valid=%b exp=0/00", busy, bus.rsp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_tie();
        logic [1:0] exp_oh;
        bus.req_op0 = 3'b001; bus.req_a0 = 32'd3;    bus.req_b0 = 32'd3;
        bus.req_op1 = 3'b011; bus.req_a1 = 32'hF0;   bus.req_b1 = 32'h0F;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++; if (bus.req_ready !== exp_oh) begin errors++; $display("FAIL tie_grant%0d got=%b exp=%b", i, bus.req_ready, exp_oh); end
            @(posedge clk);
            @(negedge clk);
            @(posedge clk);
            @(negedge clk);
            checks++; if (bus.rsp_valid !== exp_oh) begin errors++; $display("FAIL tie_rsp_valid%0d got=%b exp=%b", i, bus.rsp_valid, exp_oh); end
            if (i % 2 == 0) begin
                checks++; if (bus.rsp_result !== 32'h0) begin errors++; $display("FAIL tie_sub_result%0d got=%h exp=00000000", i, bus.rsp_result); end
                checks++; if (bus.rsp_flags !== 4'b0001) begin errors++; $display("FAIL tie_sub_flags%0d got=%b exp=0001", i, bus.rsp_flags); end
            end else begin
                checks++; if (bus.rsp_result !== 32'hFF) begin errors++; $display("FAIL tie_or_result%0d got=%h exp=000000ff", i, bus.rsp_result); end
                checks++; if (bus.rsp_flags !== 4'b0000) begin errors++; $display("FAIL tie_or_flags%0d got=%b exp=0000", i, bus.rsp_flags); end
            end
            @(posedge clk);
        end
        #1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_stall();
        bus.req_op0 = 3'b010; bus.req_a0 = 32'hFFFF0000; bus.req_b0 = 32'h12345678;
        bus.req_op1 = 3'b011; bus.req_a1 = 32'h1;        bus.req_b1 = 32'h2;
        bus.req_valid = 2'b11;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL stall_grant got=%b exp=01", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL stall_rsp_valid%0d got=%b exp=01", i, bus.rsp_valid); end
            checks++; if (bus.rsp_result !== 32'h12340000 || bus.rsp_flags !== 4'b0000) begin errors++;
                $display("FAIL stall_data%0d got=%h/%b exp=12340000/0000", i, bus.rsp_result, bus.rsp_flags); end
            checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL stall_req_ready%0d got=%b exp=00", i, bus.req_ready); end
            if (i < 4) @(posedge clk);
        end
        release_rsp(0);
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL stall_next_grant got=%b exp=10", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 32'h3) begin errors++;
            $display("FAIL stall_port1_rsp got=%b/%h exp=10/00000003", bus.rsp_valid, bus.rsp_result); end
        release_rsp(1);
    endtask

    task automatic test_alu_ops();
        logic [2:0]  t_op  [5] = '{3'b000, 3'b000, 3'b101, 3'b101, 3'b110};
        logic [31:0] t_a   [5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 32'd12};
        logic [31:0] t_b   [5] = '{32'h1, 32'h1, 32'd5, 32'h1, 32'd34};
        logic [31:0] t_res [5] = '{32'h80000000, 32'h0, 32'h1, 32'h0, 32'h0};
        logic [3:0]  t_flg [5] = '{4'b1010, 4'b0101, 4'b0000, 4'b0001, 4'b0001};
        logic [1:0]  rdy;
        for (int i = 0; i < 5; i++) begin
            issue(i % 2, t_op[i], t_a[i], t_b[i], rdy);
            checks++; if (bus.rsp_valid !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++;
                $display("FAIL ops_rsp_valid%0d got=%b rdy=%b", i, bus.rsp_valid, rdy); end
            checks++; if (bus.rsp_result !== t_res[i]) begin errors++; $display("FAIL ops_result%0d got=%h exp=%h", i, bus.rsp_result, t_res[i]); end
            checks++; if (bus.rsp_flags !== t_flg[i]) begin errors++; $display("FAIL ops_flags%0d got=%b exp=%b", i, bus.rsp_flags, t_flg[i]); end
            release_rsp(i % 2);
        end
    endtask

    task automatic test_reset_resp();
        logic [1:0] rdy;
        issue(0, 3'b000, 32'd1, 32'd1, rdy);
        checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd2) begin errors++;
            $display("FAIL rst_resp_pre got=%b/%h exp=01/00000002", bus.rsp_valid, bus.rsp_result); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req_valid = 2'b11;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got=%b exp=00", bus.rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_resp_busy got=%b exp=0", busy); end
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rst_resp_tie got=%b exp=01", bus.req_ready); end
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req_op0   = 3'b000;
        bus.req_op1   = 3'b000;
        bus.req_a0    = '0;
        bus.req_b0    = '0;
        bus.req_a1    = '0;
        bus.req_b1    = '0;
        test_reset();
        test_single_add();
        test_tie();
        test_stall();
        test_alu_ops();
        test_reset_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
